// File: rtl/snitch_icache_perf_counters_pkg.sv
// Shared types and constants for the instruction-cache performance counter unit.
package snitch_icache_perf_counters_pkg;

  localparam int unsigned NUM_L0_EVENTS = 5;
  localparam int unsigned NUM_L1_EVENTS = 4;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_FREEZE_BIT = 1;
  localparam int unsigned CTRL_CLEAR_BIT  = 2;
  localparam int unsigned CTRL_SAT_BIT    = 3;

  // Field order puts 'miss' at bit 0 so event index e equals bit position e.
  typedef struct packed {
    logic stall;
    logic double_hit;
    logic prefetch;
    logic hit;
    logic miss;
  } icache_l0_events_t;

  typedef struct packed {
    logic handler_stall;
    logic stall;
    logic hit;
    logic miss;
  } icache_l1_events_t;

  typedef struct packed {
    logic sat;
    logic clear;
    logic freeze;
    logic en;
  } perf_ctrl_t;

  // Word address of the L0 counter for a given fetch port and event.
  function automatic int unsigned perf_l0_addr(input int unsigned port, input int unsigned evt);
    return 1 + port * NUM_L0_EVENTS + evt;
  endfunction

  // Word address of an L1 counter; it sits right after all L0 counters.
  function automatic int unsigned perf_l1_addr(input int unsigned nr_ports, input int unsigned evt);
    return 1 + nr_ports * NUM_L0_EVENTS + evt;
  endfunction

endpackage

// File: rtl/snitch_icache_perf_cnt.sv
// A single event counter with a sticky overflow flag, wrap or saturate on overflow.
module snitch_icache_perf_cnt
  import snitch_icache_perf_counters_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_val_i,
  input  logic                 clear_i,
  input  logic                 ovf_clr_i,
  input  logic                 sat_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 ovf_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  // Next state: global clear beats an explicit load, which beats an increment.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load_i) begin
      cnt_d = load_val_i;
      ovf_d = 1'b0;
    end else begin
      if (ovf_clr_i) begin
        ovf_d = 1'b0;
      end
      if (inc_i) begin
        if (&cnt_q) begin
          ovf_d = 1'b1;
          cnt_d = sat_i ? cnt_q : '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Counter and overflow state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/snitch_icache_perf_counters.sv
// Memory-mapped performance counters for the instruction cache L0 and L1 events.
module snitch_icache_perf_counters
  import snitch_icache_perf_counters_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS   = 2,
  parameter int unsigned CNT_WIDTH        = 32,
  parameter bit          SATURATE_DEFAULT = 1'b0,
  parameter int unsigned ADDR_WIDTH       = 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  icache_l0_events_t [NR_FETCH_PORTS-1:0]   l0_events_i,
  input  icache_l1_events_t                        l1_events_i,
  input  logic                                     req_i,
  input  logic                                     we_i,
  input  logic [ADDR_WIDTH-1:0]                    addr_i,
  input  logic [31:0]                              wdata_i,
  output logic                                     gnt_o,
  output logic                                     rvalid_o,
  output logic [31:0]                              rdata_o,
  output logic                                     ovf_irq_o
);

  localparam int unsigned NUM_CNT      = NR_FETCH_PORTS * NUM_L0_EVENTS + NUM_L1_EVENTS;
  localparam int unsigned OVF_CLR_ADDR = NUM_CNT + 1;

  logic [NUM_CNT-1:0]   evtVec, load, ovfClr, ovf;
  logic [CNT_WIDTH-1:0] cnt     [NUM_CNT];
  logic [31:0]          cntWord [NUM_CNT];

  perf_ctrl_t  ctrl_q, ctrl_d;
  logic        wrAccess, ctrlWrite, ovfClrWrite, clearAll, countEn;
  logic        rvalid_q, ovfIrq_q;
  logic [31:0] rdata_q, rdata_d;

  assign evtVec[NR_FETCH_PORTS*NUM_L0_EVENTS-1:0] = l0_events_i;
  assign evtVec[NUM_CNT-1 -: NUM_L1_EVENTS]       = l1_events_i;

  assign wrAccess    = req_i && we_i;
  assign ctrlWrite   = wrAccess && (addr_i == '0);
  assign ovfClrWrite = wrAccess && (addr_i == ADDR_WIDTH'(OVF_CLR_ADDR));
  assign clearAll    = ctrlWrite && wdata_i[CTRL_CLEAR_BIT];
  assign countEn     = ctrl_q.en && !ctrl_q.freeze;

  for (genvar k = 0; k < NUM_CNT; k++) begin : gen_cnt
    assign load[k] = wrAccess && (addr_i == ADDR_WIDTH'(k + 1));

    // Only the first 32 counters have a bit in the OVF_CLR write mask.
    if (k < 32) begin : gen_clr
      assign ovfClr[k] = ovfClrWrite && wdata_i[k];
    end else begin : gen_noclr
      assign ovfClr[k] = 1'b0;
    end

    // At full 32-bit width the count MSB owns bit 31, so ovf is irq-only.
    if (CNT_WIDTH < 32) begin : gen_word_ovf
      assign cntWord[k] = {ovf[k], 31'(cnt[k])};
    end else begin : gen_word_full
      assign cntWord[k] = 32'(cnt[k]);
    end

    snitch_icache_perf_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (countEn && evtVec[k]),
      .load_i     (load[k]),
      .load_val_i (wdata_i[CNT_WIDTH-1:0]),
      .clear_i    (clearAll),
      .ovf_clr_i  (ovfClr[k]),
      .sat_i      (ctrl_q.sat),
      .cnt_o      (cnt[k]),
      .ovf_o      (ovf[k])
    );
  end

  // CTRL update; the clear bit acts as a strobe and is never stored.
  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrlWrite) begin
      ctrl_d.en     = wdata_i[CTRL_EN_BIT];
      ctrl_d.freeze = wdata_i[CTRL_FREEZE_BIT];
      ctrl_d.sat    = wdata_i[CTRL_SAT_BIT];
      ctrl_d.clear  = 1'b0;
    end
  end

  // Read mux over pre-update state; writes and unmapped addresses return 0.
  always_comb begin
    rdata_d = '0;
    if (req_i && !we_i) begin
      if (addr_i == '0) begin
        rdata_d = {28'b0, ctrl_q.sat, 1'b0, ctrl_q.freeze, ctrl_q.en};
      end
      for (int k = 0; k < NUM_CNT; k++) begin
        if (addr_i == ADDR_WIDTH'(k + 1)) begin
          rdata_d = cntWord[k];
        end
      end
    end
  end

  // Control register, registered response port and overflow interrupt.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q   <= perf_ctrl_t'{sat: SATURATE_DEFAULT, clear: 1'b0, freeze: 1'b0, en: 1'b0};
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ovfIrq_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
      ovfIrq_q <= |ovf;
    end
  end

  assign gnt_o     = 1'b1;
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = rdata_q;
  assign ovf_irq_o = ovfIrq_q;

endmodule

// File: tb/tb_snitch_icache_perf_counters.sv
// Randomised and directed checks of the icache performance counters against a rule-level model.
module tb_snitch_icache_perf_counters;
  import snitch_icache_perf_counters_pkg::*;

  localparam int unsigned NRP    = 2;
  localparam int unsigned CW     = 8;
  localparam bit          SATDEF = 1'b1;
  localparam int unsigned NCNT   = NRP * 5 + 4;
  localparam int unsigned OVFA   = NCNT + 1;
  localparam int unsigned CMAX   = (1 << CW) - 1;

  logic                         clk, rst_n;
  icache_l0_events_t [NRP-1:0]  l0Ev;
  icache_l1_events_t            l1Ev;
  logic                         req, we;
  logic [7:0]                   addr;
  logic [31:0]                  wdata;
  logic                         gnt, rvalid, irq;
  logic [31:0]                  rdata;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int unsigned mCnt [NCNT];
  bit          mOvf [NCNT];
  bit          mEn, mFreeze, mSat;
  logic [31:0] expRdata;
  bit          expRvalid, expIrq;

  snitch_icache_perf_counters #(
    .NR_FETCH_PORTS   (NRP),
    .CNT_WIDTH        (CW),
    .SATURATE_DEFAULT (SATDEF),
    .ADDR_WIDTH       (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .l0_events_i (l0Ev),
    .l1_events_i (l1Ev),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .ovf_irq_o   (irq)
  );

  // 10 time-unit clock.
  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int k = 0; k < NCNT; k++) begin
      mCnt[k] = 0;
      mOvf[k] = 1'b0;
    end
    mEn = 1'b0; mFreeze = 1'b0; mSat = SATDEF;
  endfunction

  function automatic logic [31:0] modelRead(input logic [7:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 8'd0) v = {28'b0, mSat, 1'b0, mFreeze, mEn};
    else if (int'(a) <= NCNT) v = {mOvf[a-1], 23'b0, 8'(mCnt[a-1])};
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model by the same rules, and land #1 after the edge.
  task automatic step(input logic [NRP*5-1:0] l0, input logic [3:0] l1, input bit rq,
                      input bit w, input logic [7:0] a, input logic [31:0] wd);
    bit anyOvf, doCount, clr;
    logic [NCNT-1:0] all;
    l0Ev = l0; l1Ev = l1; req = rq; we = w; addr = a; wdata = wd;
    expRvalid = rq;
    expRdata  = (rq && !w) ? modelRead(a) : 32'd0;
    anyOvf = 1'b0;
    for (int k = 0; k < NCNT; k++) anyOvf = anyOvf | mOvf[k];
    expIrq  = anyOvf;
    doCount = mEn && !mFreeze;
    clr     = rq && w && (a == 8'd0) && wd[2];
    all     = {l1, l0};
    for (int k = 0; k < NCNT; k++) begin
      if (clr) begin
        mCnt[k] = 0; mOvf[k] = 1'b0;
      end else if (rq && w && (a == 8'(k + 1))) begin
        mCnt[k] = wd & CMAX; mOvf[k] = 1'b0;
      end else begin
        if (rq && w && (a == 8'(OVFA)) && wd[k]) mOvf[k] = 1'b0;
        if (doCount && all[k]) begin
          if (mCnt[k] == CMAX) begin
            mOvf[k] = 1'b1;
            if (!mSat) mCnt[k] = 0;
          end else begin
            mCnt[k] = mCnt[k] + 1;
          end
        end
      end
    end
    if (rq && w && (a == 8'd0)) begin
      mEn = wd[0]; mFreeze = wd[1]; mSat = wd[3];
    end
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [7:0] a);
    step('0, '0, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    step('0, '0, 1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input logic [NRP*5-1:0] l0, input logic [3:0] l1);
    step(l0, l1, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; l0Ev = '0; l1Ev = '0;
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (gnt !== 1'b1) begin errors++; $display("[TB] FAIL gnt: got %b expected 1", gnt); end
    rd(8'd0);
    checks++; if (rdata !== 32'h8) begin errors++; $display("[TB] FAIL reset_ctrl: got %h expected 8", rdata); end
    for (int a = 1; a <= OVFA; a++) begin
      rd(8'(a));
      checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt%0d: got %h expected 0", a, rdata); end
    end
  endtask

  task automatic test_count();
    logic [7:0] hitA;
    hitA = 8'(perf_l0_addr(0, 1));
    wr(8'd0, 32'h1);
    repeat (10) idle(10'b00000_00010, 4'b0);
    rd(hitA);
    checks++; if (rdata !== 32'd10) begin errors++; $display("[TB] FAIL count_hit: got %h expected 10", rdata); end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL count_rvalid: got %b expected 1", rvalid); end
    idle('0, '0);
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL count_rvalid_drop: got %b expected 0", rvalid); end
    for (int a = 1; a <= NCNT; a++) begin
      if (a != 2) begin
        rd(8'(a));
        checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL count_other%0d: got %h expected 0", a, rdata); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] missA;
    missA = 8'(perf_l1_addr(NRP, 0));
    wr(8'd0, 32'h1);
    wr(missA, 32'hFE);
    repeat (3) idle('0, 4'b0001);
    rd(missA);
    checks++; if (rdata !== 32'h80000001) begin errors++; $display("[TB] FAIL wrap_value: got %h expected 80000001", rdata); end
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL wrap_irq: got %b expected 1", irq); end
  endtask

  task automatic test_saturate();
    logic [7:0] missA;
    missA = 8'(perf_l1_addr(NRP, 0));
    wr(8'd0, 32'h9);
    wr(missA, 32'hFE);
    repeat (3) idle('0, 4'b0001);
    rd(missA);
    checks++; if (rdata !== 32'h800000FF) begin errors++; $display("[TB] FAIL sat_value: got %h expected 800000FF", rdata); end
    wr(8'(OVFA), 32'h400);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL sat_irq_hold: got %b expected 1", irq); end
    rd(missA);
    checks++; if (rdata !== 32'h000000FF) begin errors++; $display("[TB] FAIL sat_ovfclr: got %h expected 000000FF", rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL sat_irq_drop: got %b expected 0", irq); end
  endtask

  task automatic test_freeze();
    logic [7:0] dhA;
    dhA = 8'(perf_l0_addr(0, 3));
    wr(8'd0, 32'h1);
    wr(dhA, 32'h0);
    repeat (5) idle(10'b00000_01000, 4'b0);
    wr(8'd0, 32'h3);
    repeat (7) idle(10'b00000_01000, 4'b0);
    rd(dhA);
    checks++; if (rdata !== 32'd5) begin errors++; $display("[TB] FAIL freeze_hold: got %h expected 5", rdata); end
    wr(8'd0, 32'h1);
    repeat (2) idle(10'b00000_01000, 4'b0);
    rd(dhA);
    checks++; if (rdata !== 32'd7) begin errors++; $display("[TB] FAIL freeze_resume: got %h expected 7", rdata); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] dhA;
    dhA = 8'(perf_l0_addr(0, 3));
    step(10'b00000_01000, 4'b0, 1'b1, 1'b1, dhA, 32'h20);
    rd(dhA);
    checks++; if (rdata !== 32'h20) begin errors++; $display("[TB] FAIL write_beats_inc: got %h expected 20", rdata); end
    step('1, 4'hF, 1'b1, 1'b1, 8'd0, 32'h5);
    for (int a = 1; a <= NCNT; a++) begin
      rd(8'(a));
      checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL clear_cnt%0d: got %h expected 0", a, rdata); end
    end
    rd(8'd0);
    checks++; if (rdata !== 32'h1) begin errors++; $display("[TB] FAIL clear_ctrl: got %h expected 1", rdata); end
    repeat (3) idle('1, 4'hF);
    rd(8'd1);
    checks++; if (rdata !== 32'd3) begin errors++; $display("[TB] FAIL clear_resume_l0: got %h expected 3", rdata); end
    rd(8'(NCNT));
    checks++; if (rdata !== 32'd3) begin errors++; $display("[TB] FAIL clear_resume_l1: got %h expected 3", rdata); end
  endtask

  task automatic test_out_of_range();
    rd(8'hFF);
    checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL oor_rdata: got %h expected 0", rdata); end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL oor_rvalid: got %b expected 1", rvalid); end
    wr(8'hFF, 32'h55);
    checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL write_rdata: got %h expected 0", rdata); end
    checks++; if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL write_rvalid: got %b expected 1", rvalid); end
    wr(8'h20, 32'h77);
    rd(8'(OVFA));
    checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL ovfclr_read: got %h expected 0", rdata); end
    rd(8'd1);
    checks++; if (rdata !== 32'd3) begin errors++; $display("[TB] FAIL oor_nochange: got %h expected 3", rdata); end
  endtask

  task automatic test_random();
    int op;
    logic [NRP*5-1:0] l0r;
    logic [3:0] l1r;
    logic [7:0] a;
    logic [31:0] cw;
    wr(8'd0, 32'h1);
    for (int i = 0; i < 400; i++) begin
      op  = $urandom_range(0, 19);
      l0r = (NRP*5)'($urandom);
      l1r = 4'($urandom);
      a   = 8'($urandom_range(0, OVFA + 2));
      if (op < 12) begin
        step(l0r, l1r, 1'b1, 1'b0, a, 32'd0);
      end else if (op < 15) begin
        step(l0r, l1r, 1'b1, 1'b1, 8'($urandom_range(1, NCNT)),
             ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(240, 255)));
      end else if (op == 15) begin
        step(l0r, l1r, 1'b1, 1'b1, 8'(OVFA), $urandom);
      end else if (op == 16) begin
        cw = {28'b0, 1'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0), 1'b1};
        step(l0r, l1r, 1'b1, 1'b1, 8'd0, cw);
      end else begin
        step(l0r, l1r, 1'b0, 1'b0, a, 32'd0);
      end
      checks++; if (rvalid !== expRvalid) begin errors++; $display("[TB] FAIL rand_rvalid@%0d: got %b expected %b", i, rvalid, expRvalid); end
      checks++; if (rdata !== expRdata) begin errors++; $display("[TB] FAIL rand_rdata@%0d: got %h expected %h", i, rdata, expRdata); end
      checks++; if (irq !== expIrq) begin errors++; $display("[TB] FAIL rand_irq@%0d: got %b expected %b", i, irq, expIrq); end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] missA;
    missA = 8'(perf_l1_addr(NRP, 0));
    wr(8'd0, 32'h1);
    wr(missA, 32'hFF);
    idle('1, 4'b0001);
    idle('1, 4'b0001);
    step('1, 4'hF, 1'b1, 1'b0, missA, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL async_rvalid: got %b expected 0", rvalid); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL async_rdata: got %h expected 0", rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL async_irq: got %b expected 0", irq); end
    req = 1'b0; we = 1'b0; l0Ev = '0; l1Ev = '0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rd(8'd0);
    checks++; if (rdata !== 32'h8) begin errors++; $display("[TB] FAIL async_ctrl: got %h expected 8", rdata); end
    for (int a = 1; a <= NCNT; a++) begin
      rd(8'(a));
      checks++; if (rdata !== 32'd0) begin errors++; $display("[TB] FAIL async_cnt%0d: got %h expected 0", a, rdata); end
    end
  endtask

  initial begin
    clk = 1'b0;
    applyReset();
    test_reset();
    test_count();
    test_wrap();
    test_saturate();
    test_freeze();
    test_back_to_back();
    test_out_of_range();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snitch_icache_perf_counters.md
Name: snitch_icache_perf_counters

Overview:
Memory-mapped performance counter unit for the instruction cache.
- Counts every bit of the per-port L0 event vectors (icache_l0_events_t, 5 events each) and the shared L1 event vector (icache_l1_events_t, 4 events).
- Generalised over fetch-port count, counter width and overflow mode (wrap or saturate), with freeze, global clear and per-counter preload.
- Sits beside the icache root and is read by the cluster peripheral interconnect through a simple req/gnt register port.

Parameters:
- NR_FETCH_PORTS, 2, number of L0 event vectors; legal range 1..8.
- CNT_WIDTH, 32, counter width; legal range 8..32.
- SATURATE_DEFAULT, 0, reset value of the CTRL.sat bit.
- ADDR_WIDTH, 8, word-address width of the register port.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- l0_events_i  in  NR_FETCH_PORTS x icache_l0_events_t  per-port L0 events; sampled every cycle
- l1_events_i  in  icache_l1_events_t  L1 events; sampled every cycle
- req_i  in  1  register access request
- we_i  in  1  write enable
- addr_i  in  ADDR_WIDTH  word address
- wdata_i  in  32  write data
- gnt_o  out  1  grant; tied to 1
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- ovf_irq_o  out  1  OR of all sticky overflow flags

Behaviour:
- NUM_CNT = NR_FETCH_PORTS*5 + 4.
- Register map:
  - Address 0: CTRL. Bit0 en (reset 0), bit1 freeze (reset 0), bit2 clear (write-only, reads 0), bit3 sat (reset SATURATE_DEFAULT).
  - Address 1+p*5+e: L0 counter for port p, event e. Event order: miss, hit, prefetch, double_hit, stall.
  - Address 1+NR_FETCH_PORTS*5+e: L1 counter, e in order miss, hit, stall, handler_stall.
  - Address 1+NUM_CNT: OVF_CLR (write-only).
- Counter readout: bit31 = sticky ovf flag, bits CNT_WIDTH-1:0 = count, other bits 0. For CNT_WIDTH=32, bit31 is the count MSB and ovf is readable only via ovf_irq_o.
- Counting:
  - When en=1 and freeze=0, a counter increments by 1 on every cycle its event bit is 1.
  - The new value is readable from the next cycle. Maximum one increment per cycle per counter.
- Overflow:
  - Increment at all-ones with sat=0: wraps to 0 and sets ovf.
  - Increment at all-ones with sat=1: holds at all-ones and sets ovf.
  - ovf stays set until cleared.
- Register port:
  - gnt_o is constantly 1; one access accepted per cycle.
  - rvalid_o is asserted exactly one cycle after any accepted req, for both reads and writes.
  - rdata_o carries the read value; it is 0 for writes.
- Writes:
  - Write to a counter loads wdata_i[CNT_WIDTH-1:0] and clears its ovf. It takes effect next cycle.
  - Write to CTRL with bit2=1 zeroes all counters and all ovf flags next cycle. The other CTRL bits are updated from the same write.
  - Write to OVF_CLR clears every ovf flag whose index bit in wdata_i is 1. Bit k maps to counter k; only counters 0..31 are reachable.
  - Addresses beyond 1+NUM_CNT: reads return 0, writes are ignored.
- Priority on the same counter in the same cycle: clear > explicit write > increment. A dropped increment does not set ovf.
- Read in the same cycle as an increment returns the pre-increment value.
- Reset: all counters 0, ovf 0, CTRL = {sat=SATURATE_DEFAULT, freeze=0, en=0}, rvalid_o=0, rdata_o=0, ovf_irq_o=0. Asserting reset mid-count discards all state asynchronously.
- ovf_irq_o is registered: it asserts one cycle after the flag sets.

Decomposition:
- Shared package additions:
  - NUM_L0_EVENTS=5 and NUM_L1_EVENTS=4 localparams.
  - CTRL bit-index constants.
  - Register index helper function (port, event) -> address.
  - perf_ctrl_t packed struct {sat, clear, freeze, en}.
- Sub-module snitch_icache_perf_cnt: one counter plus sticky ovf.
  - Inputs: inc, load, load_val, clear, sat.
  - Outputs: cnt, ovf.
  - Instantiated NUM_CNT times from a generate loop.

Test Plan:
- Reset, write CTRL=0x1, drive l0_events_i[0].l0_hit for 10 cycles -> read address 2 returns 10; every other counter reads 0; rvalid_o high exactly one cycle after each req.
- CNT_WIDTH=8, sat=0, preload 0xFE into L1 miss (address 11), 3 miss events -> reads 0x80000001; ovf_irq_o=1.
- Same preload with sat=1 -> reads 0x800000FF. Then write OVF_CLR with bit10 set -> reads 0x000000FF and ovf_irq_o drops one cycle later.
- Count 5 events, set freeze=1, drive 7 more events -> counter stays 5. Clear freeze, 2 more events -> 7.
- Same-cycle write 0x20 and event on one counter -> reads 0x20. Then CTRL write 0x5 during active events -> all counters 0 next cycle, counting resumes after.
- Read address 0xFF -> rdata_o=0 and rvalid_o=1. Assert rst_ni low mid-count -> all reads return 0 and CTRL reads SATURATE_DEFAULT<<3.
